// File: rtl/clause_status_collector.sv
// clause_status_collector
// Snapshots the per-clause terminal-cell drive bits (csat/imp/conflict) and
// cmax_lvl on request, then scans one clause per cycle and publishes a
// registered summary (conflict, first conflicting clause, conflict level,
// first implying clause, implying count, all-satisfied) for the sat_engine FSM.
//
// Optional build macro: COLLECT_EARLY_EXIT_EN
//   When defined, the scan stops at the first conflicting clause; results then
//   cover clauses 0..cid only and all_sat_o is forced low.
//
// state | meaning
// IDLE  | waiting for start_i; results hold from the previous pass
// SCAN  | evaluating snapshot clause idx_q, one per cycle
// DONE  | one-cycle done_o pulse, results valid
module clause_status_collector #(
  parameter int NUM_C     = 8,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_CID = 3,
  parameter int WIDTH_CNT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [NUM_C-1:0]           csat_drv_i,
  input  logic [NUM_C-1:0]           imp_drv_i,
  input  logic [NUM_C-1:0]           conflict_c_drv_i,
  input  logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       conflict_o,
  output logic [WIDTH_CID-1:0]       conflict_cid_o,
  output logic [WIDTH_LVL-1:0]       conflict_lvl_o,
  output logic                       imp_o,
  output logic [WIDTH_CID-1:0]       imp_cid_o,
  output logic [WIDTH_CNT-1:0]       imp_cnt_o,
  output logic                       all_sat_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [WIDTH_CID-1:0] LAST_IDX = WIDTH_CID'(NUM_C - 1);
  localparam logic [WIDTH_CNT-1:0] CNT_MAX  = {WIDTH_CNT{1'b1}};

  state_t                     state_q;
  logic [WIDTH_CID-1:0]       idx_q;

  // Snapshot taken at the accepting edge; live inputs are not looked at again.
  logic [NUM_C-1:0]           snap_csat_q;
  logic [NUM_C-1:0]           snap_imp_q;
  logic [NUM_C-1:0]           snap_conf_q;
  logic [NUM_C*WIDTH_LVL-1:0] snap_lvl_q;

  // Running accumulators; published to the outputs only when the scan ends.
  logic                       acc_conf_q,    acc_conf_d;
  logic [WIDTH_CID-1:0]       acc_cid_q,     acc_cid_d;
  logic [WIDTH_LVL-1:0]       acc_lvl_q,     acc_lvl_d;
  logic                       acc_imp_q,     acc_imp_d;
  logic [WIDTH_CID-1:0]       acc_imp_cid_q, acc_imp_cid_d;
  logic [WIDTH_CNT-1:0]       acc_cnt_q,     acc_cnt_d;
  logic                       acc_sat_q,     acc_sat_d;
  logic                       scan_last;

  logic                       cur_conf;
  logic                       cur_imp;
  logic                       cur_csat;
  logic [WIDTH_LVL-1:0]       cur_lvl;

  // Fold the clause at idx_q into the accumulators and decide if the scan ends.
  always_comb begin
    cur_conf      = snap_conf_q[idx_q];
    cur_imp       = snap_imp_q[idx_q];
    cur_csat      = snap_csat_q[idx_q];
    cur_lvl       = snap_lvl_q[int'(idx_q) * WIDTH_LVL +: WIDTH_LVL];

    acc_conf_d    = acc_conf_q;
    acc_cid_d     = acc_cid_q;
    acc_lvl_d     = acc_lvl_q;
    acc_imp_d     = acc_imp_q;
    acc_imp_cid_d = acc_imp_cid_q;
    acc_cnt_d     = acc_cnt_q;
    acc_sat_d     = acc_sat_q;
    scan_last     = (idx_q == LAST_IDX);

    if (cur_conf) begin
      acc_conf_d = 1'b1;
      if (!acc_conf_q) acc_cid_d = idx_q;
      if (cur_lvl > acc_lvl_q) acc_lvl_d = cur_lvl;
    end

    if (cur_imp) begin
      acc_imp_d = 1'b1;
      if (!acc_imp_q) acc_imp_cid_d = idx_q;
      if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + 1'b1;
    end

    if (!cur_csat) acc_sat_d = 1'b0;

`ifdef COLLECT_EARLY_EXIT_EN
    // First conflict ends the pass; its level is the only one that counts.
    if (cur_conf) begin
      scan_last = 1'b1;
      acc_lvl_d = cur_lvl;
      acc_sat_d = 1'b0;
    end
`endif
  end

  // Sequencer FSM with snapshot, accumulators and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      snap_csat_q    <= '0;
      snap_imp_q     <= '0;
      snap_conf_q    <= '0;
      snap_lvl_q     <= '0;
      acc_conf_q     <= 1'b0;
      acc_cid_q      <= '0;
      acc_lvl_q      <= '0;
      acc_imp_q      <= 1'b0;
      acc_imp_cid_q  <= '0;
      acc_cnt_q      <= '0;
      acc_sat_q      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      conflict_o     <= 1'b0;
      conflict_cid_o <= '0;
      conflict_lvl_o <= '0;
      imp_o          <= 1'b0;
      imp_cid_o      <= '0;
      imp_cnt_o      <= '0;
      all_sat_o      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          if (start_i) begin
            snap_csat_q    <= csat_drv_i;
            snap_imp_q     <= imp_drv_i;
            snap_conf_q    <= conflict_c_drv_i;
            snap_lvl_q     <= cmax_lvl_i;
            acc_conf_q     <= 1'b0;
            acc_cid_q      <= '0;
            acc_lvl_q      <= '0;
            acc_imp_q      <= 1'b0;
            acc_imp_cid_q  <= '0;
            acc_cnt_q      <= '0;
            acc_sat_q      <= 1'b1;
            conflict_o     <= 1'b0;
            conflict_cid_o <= '0;
            conflict_lvl_o <= '0;
            imp_o          <= 1'b0;
            imp_cid_o      <= '0;
            imp_cnt_o      <= '0;
            all_sat_o      <= 1'b0;
            idx_q          <= '0;
            busy_o         <= 1'b1;
            state_q        <= SCAN;
          end
        end
        SCAN: begin
          acc_conf_q    <= acc_conf_d;
          acc_cid_q     <= acc_cid_d;
          acc_lvl_q     <= acc_lvl_d;
          acc_imp_q     <= acc_imp_d;
          acc_imp_cid_q <= acc_imp_cid_d;
          acc_cnt_q     <= acc_cnt_d;
          acc_sat_q     <= acc_sat_d;
          if (scan_last) begin
            conflict_o     <= acc_conf_d;
            conflict_cid_o <= acc_cid_d;
            conflict_lvl_o <= acc_lvl_d;
            imp_o          <= acc_imp_d;
            imp_cid_o      <= acc_imp_cid_d;
            imp_cnt_o      <= acc_cnt_d;
            all_sat_o      <= acc_sat_d;
            done_o         <= 1'b1;
            state_q        <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_status_collector.sv
// Self-checking bench for clause_status_collector: directed and randomized
// passes compared against a clause-list reference model. A second instance
// with a 2-bit implying counter exercises saturation.
module tb_clause_status_collector;

  localparam int NC  = 8;
  localparam int WL  = 16;
  localparam int WC  = 3;
  localparam int WN  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NC-1:0]  csat, imp, conf;
  logic [NC*WL-1:0] lvl;

  logic           busy, done, c_o, i_o, sat_o;
  logic [WC-1:0]  cid, icid;
  logic [WL-1:0]  clvl;
  logic [WN-1:0]  icnt;

  logic           busy2, done2, c2, i2, sat2;
  logic [WC-1:0]  cid2, icid2;
  logic [WL-1:0]  clvl2;
  logic [1:0]     icnt2;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  clause_status_collector #(.NUM_C(NC), .WIDTH_LVL(WL), .WIDTH_CID(WC), .WIDTH_CNT(WN)) dut (
    .clk(clk), .rst(rst), .start_i(start),
    .csat_drv_i(csat), .imp_drv_i(imp), .conflict_c_drv_i(conf), .cmax_lvl_i(lvl),
    .busy_o(busy), .done_o(done), .conflict_o(c_o), .conflict_cid_o(cid),
    .conflict_lvl_o(clvl), .imp_o(i_o), .imp_cid_o(icid), .imp_cnt_o(icnt),
    .all_sat_o(sat_o));

  clause_status_collector #(.NUM_C(NC), .WIDTH_LVL(WL), .WIDTH_CID(WC), .WIDTH_CNT(2)) dut_sat (
    .clk(clk), .rst(rst), .start_i(start),
    .csat_drv_i(csat), .imp_drv_i(imp), .conflict_c_drv_i(conf), .cmax_lvl_i(lvl),
    .busy_o(busy2), .done_o(done2), .conflict_o(c2), .conflict_cid_o(cid2),
    .conflict_lvl_o(clvl2), .imp_o(i2), .imp_cid_o(icid2), .imp_cnt_o(icnt2),
    .all_sat_o(sat2));

  typedef struct {
    logic conf;
    int   cid;
    int   lvl;
    logic imp;
    int   imp_cid;
    int   raw_cnt;
    logic sat;
    int   lat;
  } exp_t;

  // Reference: walk the clause list (stopping at the first conflict in the
  // early-exit build) and summarise it with plain arithmetic.
  function automatic exp_t model(input logic [NC-1:0] s, input logic [NC-1:0] m,
                                 input logic [NC-1:0] c, input logic [NC*WL-1:0] l);
    exp_t e;
    int   n;
    int   v;
    e.conf = 1'b0; e.cid = 0; e.lvl = 0; e.imp = 1'b0; e.imp_cid = 0;
    e.raw_cnt = 0; e.sat = 1'b1; e.lat = NC + 1;
    n = NC;
`ifdef COLLECT_EARLY_EXIT_EN
    for (int i = NC - 1; i >= 0; i--) if (c[i]) n = i + 1;
`endif
    for (int i = 0; i < n; i++) begin
      v = int'(l[i*WL +: WL]);
      if (c[i]) begin
        if (!e.conf) e.cid = i;
        e.conf = 1'b1;
        if (v > e.lvl) e.lvl = v;
      end
      if (m[i]) begin
        if (!e.imp) e.imp_cid = i;
        e.imp = 1'b1;
        e.raw_cnt++;
      end
      if (!s[i]) e.sat = 1'b0;
    end
`ifdef COLLECT_EARLY_EXIT_EN
    if (e.conf) begin
      e.sat = 1'b0;
      e.lat = e.cid + 2;
    end
`endif
    return e;
  endfunction

  function automatic int sat_cnt(input int raw, input int maxv);
    return (raw > maxv) ? maxv : raw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, ":conflict"},     32'(c_o),   32'(e.conf));
    chk({tag, ":conflict_cid"}, 32'(cid),   32'(e.cid));
    chk({tag, ":conflict_lvl"}, 32'(clvl),  32'(e.lvl));
    chk({tag, ":imp"},          32'(i_o),   32'(e.imp));
    chk({tag, ":imp_cid"},      32'(icid),  32'(e.imp_cid));
    chk({tag, ":imp_cnt"},      32'(icnt),  32'(sat_cnt(e.raw_cnt, 15)));
    chk({tag, ":all_sat"},      32'(sat_o), 32'(e.sat));
    chk({tag, ":imp_cnt_w2"},   32'(icnt2), 32'(sat_cnt(e.raw_cnt, 3)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":busy"},  32'(busy),  0);
    chk({tag, ":done"},  32'(done),  0);
    chk({tag, ":outs"},  32'({c_o, cid, i_o, icid, icnt, sat_o}), 0);
    chk({tag, ":lvl"},   32'(clvl),  0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs;
    csat = NC'($urandom | $urandom);
    imp  = NC'($urandom & $urandom);
    conf = NC'($urandom & $urandom & $urandom);
    lvl  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One start pulse; mode 1 scrambles live inputs and re-pulses start mid-scan.
  task automatic run_pass(input string tag, input int mode);
    exp_t e;
    int   lat;
    int   nbusy;
    int   extra;
    e = model(csat, imp, conf, lvl);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    chk({tag, ":cleared_conf"}, 32'(c_o), 0);
    chk({tag, ":cleared_sat"},  32'(sat_o), 0);
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (mode == 1 && lat == 3) begin
        conf = '1;
        csat = ~csat;
        imp  = ~imp;
      end
      if (mode == 1 && lat == 4) start = 1'b1;
      if (mode == 1 && lat == 5) start = 1'b0;
      tick();
      lat++;
    end
    if (busy) nbusy++;
    chk({tag, ":done_seen"}, 32'(done), 1);
    chk({tag, ":latency"},   32'(lat), 32'(e.lat));
    chk({tag, ":busy_cyc"},  32'(nbusy), 32'(e.lat));
    chk_res(tag, e);
    tick();
    chk({tag, ":done_pulse"}, 32'(done), 0);
    chk({tag, ":busy_off"},   32'(busy), 0);
    chk({tag, ":hold_conf"},  32'(c_o),  32'(e.conf));
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (done) extra++;
        tick();
      end
      chk({tag, ":no_second_done"}, 32'(extra), 0);
    end
  endtask

  initial begin : main
    exp_t e;
    int   gap;
    int   ndone;

    rst = 1'b1; start = 1'b0;
    csat = '0; imp = '0; conf = '0; lvl = '0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // All satisfied, nothing implying or conflicting.
    csat = '1; imp = '0; conf = '0; lvl = '0;
    run_pass("all_sat", 0);

    // Clauses 2 and 5 conflicting at levels 3 and 7.
    csat = 8'hDB; imp = '0; conf = 8'b0010_0100; lvl = '0;
    lvl[2*WL +: WL] = 16'd3;
    lvl[5*WL +: WL] = 16'd7;
    run_pass("conf_2_5", 0);

    // Implying clauses 5 and 7.
    csat = '1; imp = 8'b1010_0000; conf = '0; lvl = '0;
    run_pass("imp_a0", 0);

    // All implying: wide counter counts 8, narrow one saturates at 3.
    csat = 8'h0F; imp = 8'hFF; conf = '0; lvl = {$urandom, $urandom, $urandom, $urandom};
    run_pass("imp_ff", 0);

    // Conflicts at top unsigned levels exercise the unsigned compare.
    csat = '0; imp = 8'h11; conf = 8'b1000_0010; lvl = '0;
    lvl[1*WL +: WL] = 16'h7FFF;
    lvl[7*WL +: WL] = 16'hFFFE;
    run_pass("conf_hi_lvl", 0);

    // Snapshot isolation and ignored start during busy.
    csat = '1; imp = 8'h02; conf = '0; lvl = '0;
    run_pass("snapshot", 1);

    // Reset in the 4th SCAN cycle aborts the pass.
    csat = 8'h3C; imp = 8'h40; conf = 8'h08; lvl = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_abort");
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("rst_abort:no_done", 32'(ndone), 0);
    run_pass("after_rst", 0);

    // Start held high: back-to-back passes, each on its own snapshot.
    rand_inputs();
    e = model(csat, imp, conf, lvl);
    start = 1'b1;
    gap = 0;
    while (!done && gap < 40) begin
      tick();
      gap++;
    end
    chk("held0:done_seen", 32'(done), 1);
    chk_res("held0", e);
    for (int p = 1; p <= 3; p++) begin
      rand_inputs();
      e = model(csat, imp, conf, lvl);
      gap = 0;
      do begin
        tick();
        gap++;
        if (gap == 4) rand_inputs();
      end while (!done && gap < 40);
      chk($sformatf("held%0d:period", p), 32'(gap), 32'(e.lat + 1));
      chk_res($sformatf("held%0d", p), e);
    end
    start = 1'b0;
    repeat (3) tick();

    // Randomized passes.
    for (int r = 0; r < 25; r++) begin
      rand_inputs();
      run_pass($sformatf("rand%0d", r), 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
